// File: rtl/hmac_pkg.sv
// Shared constants, state encoding and helpers for the HMAC inner-hash input padder.
package hmac_pkg;

    localparam logic [31:0] HMAC_IPAD     = 32'h36363636;
    localparam logic [31:0] HMAC_OPAD     = 32'h5c5c5c5c;
    localparam int          BLK_WORDS     = 16;
    localparam logic [3:0]  LEN_IDX_HI    = 4'd14;
    // Last index that can still carry padding zeros before the length words
    localparam logic [3:0]  LAST_ZERO_IDX = LEN_IDX_HI - 4'd1;
    localparam logic [3:0]  BLK_LAST_IDX  = 4'(BLK_WORDS - 1);
    localparam logic [31:0] PAD_WORD      = 32'h80000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_MSG,
        ST_P80,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } pad_state_e;

    // Number of valid bytes flagged in a 4-bit keep mask
    function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hmac_last_word_merge.sv
// Last-word merge: zeroes bytes beyond t_keep (MSB-first) and drops the 0x80
// terminator into the first unused byte. Also reports the valid byte count.
module hmac_last_word_merge
    import hmac_pkg::*;
(
    input  logic [31:0] t_data,
    input  logic [3:0]  t_keep,
    output logic [31:0] merged_data,
    output logic [2:0]  byte_cnt
);

    assign byte_cnt = keep_popcount(t_keep);

    // Lane gi is byte gi counted from the MSB; keep is contiguous from the MSB,
    // so the first unused lane index equals the valid byte count.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            assign merged_data[31-8*gi -: 8] = t_keep[3-gi]      ? t_data[31-8*gi -: 8] :
                                               (byte_cnt == LANE) ? 8'h80 : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/hmac_input_padder.sv
// HMAC inner-hash input padder: streams key^ipad, then message words, then the
// SHA-1 padding tail (0x80, zeros, 64-bit bit length) to the SHA-1 core.
// Optional feature macro: PADD_KEEP_EN (honour t_keep on the t_last word).
module hmac_input_padder
    import hmac_pkg::*;
#(
    parameter int          KEY_W = 512,
    parameter logic [31:0] IPAD  = HMAC_IPAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    input  logic             sel,
    input  logic             padd_start,
    input  logic             valid_to_sha,
    input  logic [31:0]      t_data,
    input  logic             t_last,
`ifdef PADD_KEEP_EN
    input  logic [3:0]       t_keep,
`endif
    input  logic             sha_ready,
    output logic [31:0]      sha_data,
    output logic             sha_valid,
    output logic             sha_first,
    output logic             sha_blk_last,
    output logic             sha_msg_last,
    output logic             pad_busy
);

    pad_state_e  state_q, state_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic [63:0] bit_len_q, bit_len_d;

    logic        xfer;
    logic [8:0]  key_lsb;
    logic [31:0] msg_data;
    logic [63:0] msg_bits;
    logic        last_full;

    // Key word 0 is the most significant 32 bits; (15 - idx) == ~idx for 4 bits
    assign key_lsb = {~word_idx_q, 5'd0};

`ifdef PADD_KEEP_EN
    logic [31:0] merged_data;
    logic [2:0]  byte_cnt;

    hmac_last_word_merge u_merge (
        .t_data      (t_data),
        .t_keep      (t_keep),
        .merged_data (merged_data),
        .byte_cnt    (byte_cnt)
    );

    assign msg_data  = t_last ? merged_data : t_data;
    assign msg_bits  = t_last ? {58'd0, byte_cnt, 3'b000} : 64'd32;
    assign last_full = (t_keep == 4'b1111);
`else
    assign msg_data  = t_data;
    assign msg_bits  = 64'd32;
    assign last_full = 1'b1;
`endif

    assign xfer = sha_valid && sha_ready;

    // State register: FSM state, in-block word index and running bit length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_idx_q <= 4'd0;
            bit_len_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            bit_len_q  <= bit_len_d;
        end
    end

    // Next-state logic: advances only on an accepted word
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        bit_len_d  = bit_len_q;
        case (state_q)
            ST_IDLE: begin
                if (padd_start) begin
                    state_d    = ST_KEY;
                    word_idx_d = 4'd0;
                    bit_len_d  = 64'd512;
                end
            end
            ST_KEY: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    if (word_idx_q == BLK_LAST_IDX) begin
                        state_d = ST_MSG;
                    end
                end
            end
            ST_MSG: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    bit_len_d  = bit_len_q + msg_bits;
                    if (t_last) begin
                        // A merged 0x80 at idx 13 leaves exactly room for the length
                        if (last_full) begin
                            state_d = ST_P80;
                        end else if (word_idx_q == LAST_ZERO_IDX) begin
                            state_d = ST_LEN_HI;
                        end else begin
                            state_d = ST_ZERO;
                        end
                    end
                end
            end
            ST_P80: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    state_d    = (word_idx_q == LAST_ZERO_IDX) ? ST_LEN_HI : ST_ZERO;
                end
            end
            ST_ZERO: begin
                // Entering at idx 15 or 0 naturally runs through an extra block
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    if (word_idx_q == LAST_ZERO_IDX) begin
                        state_d = ST_LEN_HI;
                    end
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    state_d    = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: combinational word select and sideband flags
    always_comb begin
        sha_data     = 32'd0;
        sha_valid    = 1'b0;
        sha_first    = 1'b0;
        sha_msg_last = 1'b0;
        pad_busy     = 1'b0;
        case (state_q)
            ST_KEY: begin
                sha_valid = valid_to_sha && !sel;
                sha_data  = key[key_lsb +: 32] ^ IPAD;
                sha_first = sha_valid && (word_idx_q == 4'd0);
            end
            ST_MSG: begin
                sha_valid = valid_to_sha && sel;
                sha_data  = msg_data;
            end
            ST_P80: begin
                sha_valid = 1'b1;
                sha_data  = PAD_WORD;
                pad_busy  = 1'b1;
            end
            ST_ZERO: begin
                sha_valid = 1'b1;
                pad_busy  = 1'b1;
            end
            ST_LEN_HI: begin
                sha_valid = 1'b1;
                sha_data  = bit_len_q[63:32];
                pad_busy  = 1'b1;
            end
            ST_LEN_LO: begin
                sha_valid    = 1'b1;
                sha_data     = bit_len_q[31:0];
                sha_msg_last = 1'b1;
                pad_busy     = 1'b1;
            end
            default: begin
                sha_valid = 1'b0;
            end
        endcase
        sha_blk_last = sha_valid && (word_idx_q == BLK_LAST_IDX);
    end

endmodule

// File: tb/tb_hmac_input_padder.sv
// Scoreboard bench for hmac_input_padder: a byte-level SHA-1 padding model pushes
// the expected word stream, transfers pop and compare it.
module tb_hmac_input_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] key;
    logic         sel;
    logic         padd_start;
    logic         valid_to_sha;
    logic [31:0]  t_data;
    logic         t_last;
`ifdef PADD_KEEP_EN
    logic [3:0]   t_keep;
`endif
    logic         sha_ready;
    logic [31:0]  sha_data;
    logic         sha_valid;
    logic         sha_first;
    logic         sha_blk_last;
    logic         sha_msg_last;
    logic         pad_busy;

    always #5 clk = ~clk;

    hmac_input_padder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .sel          (sel),
        .padd_start   (padd_start),
        .valid_to_sha (valid_to_sha),
        .t_data       (t_data),
        .t_last       (t_last),
`ifdef PADD_KEEP_EN
        .t_keep       (t_keep),
`endif
        .sha_ready    (sha_ready),
        .sha_data     (sha_data),
        .sha_valid    (sha_valid),
        .sha_first    (sha_first),
        .sha_blk_last (sha_blk_last),
        .sha_msg_last (sha_msg_last),
        .pad_busy     (pad_busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        blk_last;
        logic        msg_last;
        logic        busy;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg_mem [0:63];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] keep_mask(input int nb);
        case (nb)
            0:       return 4'b0000;
            1:       return 4'b1000;
            2:       return 4'b1100;
            3:       return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    // Byte-level reference: key^ipad block, message bytes, 0x80, zeros to 56 mod 64, bit length
    task automatic build_expected(input logic [511:0] k, input int nwords, input int last_bytes);
        logic [7:0]  bytes[$];
        int          l;
        int          nw;
        logic [63:0] bits;
        exp_t        e;
        for (int j = 0; j < 64; j++) bytes.push_back(8'(k >> (8 * (63 - j))) ^ 8'h36);
        l = 0;
        for (int w = 0; w < nwords; w++) begin
            int nb;
            nb = (w == nwords - 1) ? last_bytes : 4;
            for (int b = 0; b < nb; b++) begin
                bytes.push_back(8'(msg_mem[w] >> (8 * (3 - b))));
                l++;
            end
        end
        bytes.push_back(8'h80);
        while ((bytes.size() % 64) != 56) bytes.push_back(8'h00);
        bits = 64'(64 + l) * 64'd8;
        for (int b = 0; b < 8; b++) bytes.push_back(8'(bits >> (8 * (7 - b))));
        nw = bytes.size() / 4;
        for (int i = 0; i < nw; i++) begin
            e.data     = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            e.first    = (i == 0);
            e.blk_last = ((i % 16) == 15);
            e.msg_last = (i == nw - 1);
            e.busy     = (i >= 16 + nwords);
            sb_q.push_back(e);
        end
    endtask

    // Acts as the ctrl FSM for one message. ready_mode: 0 always, 1 toggle, 2 random.
    // abort_at > 0 asserts rst_n right after that many transfers.
    task automatic run_msg(input logic [511:0] k, input int nwords, input int last_bytes,
                           input int ready_mode, input bit gaps, input int abort_at);
        int          key_cnt = 0;
        int          msg_i   = 0;
        int          xfers   = 0;
        int          cycles  = 0;
        bit          done    = 0;
        bit          aborted = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = 32'd0;
        exp_t        e;
        key = k;
        build_expected(k, nwords, last_bytes);
        $display("MSG words=%0d last_bytes=%0d ready_mode=%0d gaps=%0d expected_words=%0d",
                 nwords, last_bytes, ready_mode, gaps, sb_q.size());
        @(posedge clk); #1;
        padd_start = 1'b1;
        sha_ready  = 1'b1;
        @(posedge clk); #1;
        while (!done && cycles < 3000) begin
            cycles++;
            sel        = (key_cnt >= 16);
            padd_start = (key_cnt == 5) || (msg_i >= nwords);
            if (!prev_stall) begin
                valid_to_sha = (key_cnt < 16) || (msg_i < nwords);
                if (gaps && ($urandom_range(0, 3) == 0)) valid_to_sha = 1'b0;
            end
            t_data = (msg_i < nwords) ? msg_mem[msg_i] : 32'd0;
            t_last = sel && (msg_i == nwords - 1);
`ifdef PADD_KEEP_EN
            t_keep = t_last ? keep_mask(last_bytes) : 4'b1111;
`endif
            case (ready_mode)
                0:       sha_ready = 1'b1;
                1:       sha_ready = ~sha_ready;
                default: sha_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (prev_stall) check_eq("hold_data", sha_data, prev_data);
            if (sha_valid && sha_ready) begin
                check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    $display("XFER %0d data=%08h first=%0d blk_last=%0d msg_last=%0d busy=%0d",
                             xfers, sha_data, sha_first, sha_blk_last, sha_msg_last, pad_busy);
                    check_eq("data",     sha_data,             e.data);
                    check_eq("first",    32'(sha_first),       32'(e.first));
                    check_eq("blk_last", 32'(sha_blk_last),    32'(e.blk_last));
                    check_eq("msg_last", 32'(sha_msg_last),    32'(e.msg_last));
                    check_eq("pad_busy", 32'(pad_busy),        32'(e.busy));
                end
                xfers++;
                if (!sel) key_cnt++;
                else if (msg_i < nwords) msg_i++;
                if (sha_msg_last) done = 1;
                if (abort_at > 0 && xfers == abort_at) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check_eq("rst_valid", 32'(sha_valid), 32'd0);
                    check_eq("rst_busy",  32'(pad_busy),  32'd0);
                    @(negedge clk);
                    check_eq("rst_valid_next", 32'(sha_valid), 32'd0);
                    check_eq("rst_busy_next",  32'(pad_busy),  32'd0);
                    sb_q.delete();
                    @(posedge clk); #1;
                    rst_n   = 1'b1;
                    done    = 1;
                    aborted = 1;
                end
            end
            prev_stall = sha_valid && !sha_ready;
            prev_data  = sha_data;
            if (!aborted) begin
                @(posedge clk); #1;
            end
        end
        check_eq("timeout_done", 32'(done), 32'd1);
        if (!aborted) begin
            @(posedge clk); #1;
        end
        padd_start   = 1'b0;
        valid_to_sha = 1'b0;
        sel          = 1'b0;
        t_last       = 1'b0;
        sha_ready    = 1'b1;
        @(negedge clk);
        check_eq("idle_valid", 32'(sha_valid), 32'd0);
        check_eq("idle_busy",  32'(pad_busy),  32'd0);
        check_eq("sb_empty",   32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic fill_msg();
        for (int i = 0; i < 64; i++) msg_mem[i] = $urandom;
    endtask

    initial begin
        rst_n        = 1'b0;
        key          = '0;
        sel          = 1'b0;
        padd_start   = 1'b0;
        valid_to_sha = 1'b0;
        t_data       = 32'd0;
        t_last       = 1'b0;
        sha_ready    = 1'b1;
`ifdef PADD_KEEP_EN
        t_keep       = 4'b1111;
`endif
        @(negedge clk);
        check_eq("reset_valid",    32'(sha_valid),    32'd0);
        check_eq("reset_first",    32'(sha_first),    32'd0);
        check_eq("reset_blk_last", 32'(sha_blk_last), 32'd0);
        check_eq("reset_msg_last", 32'(sha_msg_last), 32'd0);
        check_eq("reset_busy",     32'(pad_busy),     32'd0);
        check_eq("reset_data",     sha_data,          32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        fill_msg();
        msg_mem[0] = 32'h61626364;
        run_msg('0, 1, 4, 0, 0, 0);
        fill_msg();
        run_msg(rand_key(), 13, 4, 0, 0, 0);
        run_msg(rand_key(), 14, 4, 0, 0, 0);
        run_msg(rand_key(), 15, 4, 1, 0, 0);
        run_msg(rand_key(), 1, 4, 1, 1, 0);
        run_msg(rand_key(), 20, 4, 2, 1, 0);
        // Reset while the zero fill is running, then a clean restart
        run_msg(rand_key(), 1, 4, 0, 0, 20);
        run_msg(rand_key(), 2, 4, 0, 0, 0);
`ifdef PADD_KEEP_EN
        msg_mem[0] = 32'h616263ff;
        run_msg('0, 1, 3, 0, 0, 0);
        fill_msg();
        run_msg(rand_key(), 14, 2, 0, 0, 0);
        run_msg(rand_key(), 15, 1, 1, 0, 0);
        run_msg(rand_key(), 1, 0, 2, 1, 0);
        run_msg(rand_key(), 5, 4, 0, 1, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
